// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed for a w-bit unsigned value: ceil(w * log10(2)).
  // log10(2) ~= 0.30103; w*log10(2) is never an integer for w >= 1.
  function automatic int digits_for(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more,
// so the following left shift carries into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  // Pure combinational correction of a single BCD digit.
  always_comb begin
    dout = din;
    if (din >= BCD_W'(5)) dout = din + BCD_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter, one input bit per clock, with a
// Start/Busy/Done handshake, optional signed input and leading-zero mask.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [WIDTH-1:0]        Binary,
  output logic                    Busy,
  output logic                    Done,
  output logic [BCD_W*DIGITS-1:0] Out,
  output logic                    Negative,
  output logic [DIGITS-1:0]       Blank
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = BCD_W * DIGITS;

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
    $error("bin_to_bcd_seq: WIDTH must be in 2..32");
  end
  if (DIGITS < digits_for(WIDTH)) begin : g_digit_chk
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                sign_q, sign_d;
  logic [ACC_W-1:0]    out_q, out_d;
  logic                neg_q, neg_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_shift;
  logic                in_neg;
  logic [WIDTH-1:0]    in_mag;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[i*BCD_W +: BCD_W]),
      .dout (acc_adj[i*BCD_W +: BCD_W])
    );
  end

  // Leading-zero mask: scan from the top digit down, stop at first nonzero.
  // Digit 0 is never blanked so a zero value still shows one '0'.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [ACC_W-1:0] a);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (a[i*BCD_W +: BCD_W] != '0) seen = 1'b1;
      m[i] = !seen;
    end
    return m;
  endfunction

  // Input magnitude and sign; negation is kept WIDTH-bit unsigned so the
  // most negative value maps exactly onto 2^(WIDTH-1).
  always_comb begin
    in_neg = (SIGNED != 0) && Binary[WIDTH-1];
    in_mag = in_neg ? (~Binary + WIDTH'(1)) : Binary;
  end

  // Shift of the corrected accumulator, pulling in the next binary bit.
  always_comb begin
    acc_shift = {acc_adj[ACC_W-2:0], sh_q[WIDTH-1]};
  end

  // FSM next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    out_d   = out_q;
    neg_d   = neg_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SHIFT;
          sh_d    = in_mag;
          sign_d  = in_neg;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          out_d   = acc_shift;
          neg_d   = sign_q;
          blank_d = blank_mask(acc_shift);
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
      neg_q   <= 1'b0;
      blank_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      neg_q   <= neg_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Out      = out_q;
  assign Negative = neg_q;
  assign Blank    = blank_q;

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised, sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It generalises the team's fixed 16-bit converter to any input width and digit count, and adds:
- a Start/Busy/Done handshake;
- an optional two's-complement signed mode with a sign flag;
- a leading-zero blanking mask for display drivers.

It sits between datapath results and the seven-segment/readout logic.

## Interface
- WIDTH, 16, binary input width (2..32)
- DIGITS, 5, BCD digits produced; must be ≥ bcd_pkg::digits_for(WIDTH), checked by elaboration assertion
- SIGNED, 0, 1 = Binary is two's complement; Out holds magnitude, Negative holds sign

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-low reset (sampled on Clock rising edge, low = reset)
- Start  input  1  request; sampled only in IDLE
- Binary  input  WIDTH  value to convert; captured on accepted Start
- Busy  output  1  conversion in progress (SHIFT or DONE)
- Done  output  1  one-cycle pulse, Out/Negative/Blank valid and updated this cycle
- Out  output  4*DIGITS  packed BCD, digit 0 in bits [3:0]
- Negative  output  1  sign of last converted value (always 0 when SIGNED=0)
- Blank  output  DIGITS  bit i = 1 when digit i is a leading zero; bit 0 always 0

## Operation
- FSM states: IDLE, SHIFT, DONE (enum in bcd_pkg).
- IDLE + Start=1:
  - Capture the magnitude of Binary into the shift register; with SIGNED=1 and MSB=1 use the two's-complement negation, held as WIDTH-bit unsigned, so −2^(WIDTH−1) is exact.
  - Capture the sign into a pending register.
  - Clear the BCD accumulator and load bit counter = WIDTH.
  - Go to SHIFT.
- SHIFT, each cycle:
  - Every accumulator digit ≥ 5 gets +3.
  - Then {accumulator, shift register} shifts left by 1.
  - The counter decrements; at counter = 1 go to DONE.
- DONE, one cycle:
  - Done=1.
  - Out, Negative and Blank registered from the accumulator and pending sign on entry, so they are valid throughout DONE.
  - Next state IDLE.
- Out/Negative/Blank hold their last value until the next DONE; they do not change during SHIFT.
- Start while Busy=1 is ignored (no queueing). Start held high continuously produces back-to-back conversions, each re-capturing Binary.
- Binary may change freely after the capture cycle.
- Zero input: Out=0, Blank = all ones except bit 0, Negative=0 (a signed 0 is never negative).

## Timing
- Reset (Reset=0 at a rising edge): state IDLE; Busy=0, Done=0, Out=0, Negative=0, Blank=0; counter and shift registers cleared. Reset wins over every other input, including mid-SHIFT. The aborted conversion produces no Done, and Out keeps reset value 0.
- Start sampled high at edge t (IDLE): Busy=1 from t+1. SHIFT occupies cycles t+1..t+WIDTH. Done=1 and outputs valid in cycle t+WIDTH+1; Busy=0 and IDLE from t+WIDTH+2.
- Latency: WIDTH+1 cycles Start→Done. Throughput: one conversion per WIDTH+2 cycles.
- Earliest next accepted Start: the edge ending cycle t+WIDTH+2, i.e. the first IDLE cycle.
- No combinational path from inputs to outputs.

## Structure
- Package bcd_pkg:
  - state_t enum {IDLE, SHIFT, DONE};
  - constant function digits_for(w) = ceil(w·log10 2), integer-computed;
  - localparam BCD_W = 4.
- Sub-module bcd_digit_adj: combinational, one 4-bit digit in, digit+3 if ≥5 else unchanged. Instantiated DIGITS times via generate.
- The top holds the FSM, counter (clog2(WIDTH+1) bits), shift/accumulator registers, sign logic and the blank-mask scan (MSB-first, stops at the first nonzero digit).

## Test plan
- WIDTH=16, DIGITS=5, SIGNED=0:
  - Binary=16'h0B4B (2891), Start pulse → Done exactly 17 cycles later; Out=20'h02891, Blank=5'b10000, Negative=0.
  - Binary=16'hFFFF → Out=20'h65535, Blank=0. Binary=0 → Out=0, Blank=5'b11110.
- WIDTH=8, DIGITS=3, SIGNED=1:
  - Binary=8'h80 → Out=12'h128, Negative=1.
  - Binary=8'hFF → Out=12'h001, Negative=1, Blank=3'b110.
  - Binary=8'h7F → Out=12'h127, Negative=0.
- Start held high, Binary changed mid-conversion (16'h0001 then 16'h270F) → first Done gives Out=00001 (new Binary ignored while busy). The second conversion captures 16'h270F at the first IDLE edge and yields Out=09999. Busy gap is exactly one cycle.
- Reset=0 for one edge at SHIFT cycle 5 of a 2891 conversion → Busy=0 next cycle, no Done pulse, Out=0; a fresh Start afterwards converts correctly.
- Random sweep, WIDTH=16 and WIDTH=12/DIGITS=4, both SIGNED values, ≥2000 vectors vs reference model → Out, Negative and Blank match; every Done is single-cycle; Busy is never high in IDLE.
